// File: rtl/usb_speed_sequencer_if.sv
// Register-block <-> speed sequencer bus, plus the USB speed encodings
// shared by the sequencer, the autodetector and the capture path.

`ifndef USB_SPEED_AUTO
`define USB_SPEED_AUTO 2'd0
`endif
`ifndef USB_SPEED_LS
`define USB_SPEED_LS   2'd1
`endif
`ifndef USB_SPEED_FS
`define USB_SPEED_FS   2'd2
`endif
`ifndef USB_SPEED_HS
`define USB_SPEED_HS   2'd3
`endif

interface usb_speed_sequencer_if;
  logic       I_start;
  logic       I_abort;
  logic [1:0] I_mode;
  logic [1:0] I_det_speed;
  logic       O_det_restart;
  logic [1:0] O_speed;
  logic       O_locked;
  logic       O_busy;
  logic       O_error;
  logic [3:0] O_retries;

  // master: register block / autodetector side driving requests
  modport master (
    output I_start, I_abort, I_mode, I_det_speed,
    input  O_det_restart, O_speed, O_locked, O_busy, O_error, O_retries
  );

  // slave: the sequencer itself
  modport slave (
    input  I_start, I_abort, I_mode, I_det_speed,
    output O_det_restart, O_speed, O_locked, O_busy, O_error, O_retries
  );
endinterface

// File: rtl/usb_speed_sequencer.sv
// USB speed-selection supervisor: forced speed or autodetect with blanking,
// timeout and bounded retries. Optional relock on lost detection: USB_SEQ_RELOCK_EN.

module usb_speed_sequencer #(
  parameter int pTIMER_WIDTH = 22,
  parameter int pTIMEOUT     = 3000000,
  parameter int pBLANK       = 16,
  parameter int pMAX_RETRIES = 3
) (
  input logic                  fe_clk,
  input logic                  reset_n,
  usb_speed_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESTART = 3'd1,
    S_BLANK   = 3'd2,
    S_WAIT    = 3'd3,
    S_LOCKED  = 3'd4,
    S_FAIL    = 3'd5
  } state_e;

  localparam logic [pTIMER_WIDTH-1:0] BLANK_LAST   = pTIMER_WIDTH'(pBLANK - 1);
  localparam logic [pTIMER_WIDTH-1:0] TIMEOUT_LAST = pTIMER_WIDTH'(pTIMEOUT - 1);
  localparam logic [pTIMER_WIDTH-1:0] TIMER_MAX    = '1;
  localparam logic [pTIMER_WIDTH-1:0] TIMER_ONE    = pTIMER_WIDTH'(1);
  localparam logic [3:0]              MAX_RETRIES  = 4'(pMAX_RETRIES);

  state_e                  state_q;
  logic [pTIMER_WIDTH-1:0] timer_q;
  logic [3:0]              retries_q;
  logic [1:0]              speed_q;
  logic                    restart_q;
  logic                    locked_q;
  logic                    busy_q;
  logic                    error_q;

  logic [pTIMER_WIDTH-1:0] timer_inc;
  logic                    in_seq;
  logic                    start_ok;
  logic                    det_valid;
  logic                    run_start;
  logic                    forced_start;
  logic                    timeout;
  logic                    retry_fire;
  logic                    relock_fire;

  assign timer_inc    = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_ONE;
  assign in_seq       = (state_q == S_RESTART) || (state_q == S_BLANK) || (state_q == S_WAIT);
  assign start_ok     = (state_q == S_IDLE) || (state_q == S_LOCKED) || (state_q == S_FAIL);
  assign det_valid    = (bus.I_det_speed != `USB_SPEED_AUTO);

  // A start while sequencing always restarts the autodetect run, whatever the mode.
  assign run_start    = bus.I_start &&
                        (in_seq || (start_ok && (bus.I_mode == `USB_SPEED_AUTO)));
  assign forced_start = bus.I_start && start_ok && (bus.I_mode != `USB_SPEED_AUTO);
  assign timeout      = (state_q == S_WAIT) && !det_valid && (timer_q == TIMEOUT_LAST);
  assign retry_fire   = timeout && (retries_q != MAX_RETRIES) && !bus.I_start;

`ifdef USB_SEQ_RELOCK_EN
  logic auto_lock_q;  // current lock came from the autodetector
  logic miss_q;       // previous LOCKED cycle saw no detector result

  assign relock_fire = (state_q == S_LOCKED) && auto_lock_q && miss_q &&
                       !det_valid && !bus.I_start;
`else
  assign relock_fire = 1'b0;
`endif

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      retries_q   <= '0;
      speed_q     <= `USB_SPEED_AUTO;
      restart_q   <= 1'b0;
      locked_q    <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef USB_SEQ_RELOCK_EN
      auto_lock_q <= 1'b0;
      miss_q      <= 1'b0;
`endif
    end else begin
      restart_q <= 1'b0;
`ifdef USB_SEQ_RELOCK_EN
      miss_q    <= (state_q == S_LOCKED) && !det_valid;
`endif
      if (bus.I_abort) begin
        // retries survive abort so software can still read the last run
        state_q  <= S_IDLE;
        timer_q  <= '0;
        speed_q  <= `USB_SPEED_AUTO;
        locked_q <= 1'b0;
        busy_q   <= 1'b0;
        error_q  <= 1'b0;
      end else if (run_start || relock_fire || retry_fire) begin
        state_q   <= S_RESTART;
        timer_q   <= '0;
        retries_q <= retry_fire ? retries_q + 4'd1 : 4'd0;
        speed_q   <= `USB_SPEED_AUTO;
        restart_q <= 1'b1;
        locked_q  <= 1'b0;
        busy_q    <= 1'b1;
        error_q   <= 1'b0;
      end else if (forced_start) begin
        state_q     <= S_LOCKED;
        speed_q     <= bus.I_mode;
        locked_q    <= 1'b1;
        busy_q      <= 1'b0;
        error_q     <= 1'b0;
`ifdef USB_SEQ_RELOCK_EN
        auto_lock_q <= 1'b0;
`endif
      end else begin
        case (state_q)
          S_IDLE, S_LOCKED, S_FAIL: ;
          S_RESTART: begin
            state_q <= S_BLANK;
            timer_q <= '0;
          end
          S_BLANK: begin
            if (timer_q == BLANK_LAST) begin
              state_q <= S_WAIT;
              timer_q <= '0;
            end else begin
              timer_q <= timer_inc;
            end
          end
          S_WAIT: begin
            // a result arriving on the timeout cycle still locks
            if (det_valid) begin
              state_q     <= S_LOCKED;
              speed_q     <= bus.I_det_speed;
              locked_q    <= 1'b1;
              busy_q      <= 1'b0;
`ifdef USB_SEQ_RELOCK_EN
              auto_lock_q <= 1'b1;
`endif
            end else if (timeout) begin
              state_q <= S_FAIL;
              speed_q <= `USB_SPEED_AUTO;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end else begin
              timer_q <= timer_inc;
            end
          end
          default: begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            speed_q  <= `USB_SPEED_AUTO;
            locked_q <= 1'b0;
            busy_q   <= 1'b0;
            error_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.O_det_restart = restart_q;
  assign bus.O_speed       = speed_q;
  assign bus.O_locked      = locked_q;
  assign bus.O_busy        = busy_q;
  assign bus.O_error       = error_q;
  assign bus.O_retries     = retries_q;

endmodule

// File: tb/tb_usb_speed_sequencer.sv
// Directed bench for usb_speed_sequencer (pTIMEOUT=100, pBLANK=4, pMAX_RETRIES=2).

`ifndef USB_SPEED_AUTO
`define USB_SPEED_AUTO 2'd0
`endif
`ifndef USB_SPEED_LS
`define USB_SPEED_LS   2'd1
`endif
`ifndef USB_SPEED_FS
`define USB_SPEED_FS   2'd2
`endif
`ifndef USB_SPEED_HS
`define USB_SPEED_HS   2'd3
`endif

module tb_usb_speed_sequencer;
  logic fe_clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   pulse_q[$];
  int   n_pulses;

  usb_speed_sequencer_if u_if ();

  usb_speed_sequencer #(
    .pTIMER_WIDTH(22),
    .pTIMEOUT    (100),
    .pBLANK      (4),
    .pMAX_RETRIES(2)
  ) dut (
    .fe_clk (fe_clk),
    .reset_n(reset_n),
    .bus    (u_if.slave)
  );

  always #5 fe_clk = ~fe_clk;

  always @(posedge fe_clk) cyc <= cyc + 1;
  always @(negedge fe_clk) if (u_if.O_det_restart === 1'b1) pulse_q.push_back(cyc);

  task automatic tick();
    @(posedge fe_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    u_if.I_start     = 1'b0;
    u_if.I_abort     = 1'b0;
    u_if.I_mode      = `USB_SPEED_AUTO;
    u_if.I_det_speed = `USB_SPEED_AUTO;
    repeat (2) tick();
    chk("rst_speed",   32'(u_if.O_speed), 32'(`USB_SPEED_AUTO));
    chk("rst_restart", 32'(u_if.O_det_restart), 0);
    chk("rst_locked",  32'(u_if.O_locked), 0);
    chk("rst_busy",    32'(u_if.O_busy), 0);
    chk("rst_error",   32'(u_if.O_error), 0);
    chk("rst_retries", 32'(u_if.O_retries), 0);
    reset_n = 1'b1;
    tick();

    // forced HS
    u_if.I_mode = `USB_SPEED_HS; u_if.I_start = 1'b1;
    tick();
    u_if.I_start = 1'b0;
    chk("hs_locked",  32'(u_if.O_locked), 1);
    chk("hs_speed",   32'(u_if.O_speed), 32'(`USB_SPEED_HS));
    chk("hs_restart", 32'(u_if.O_det_restart), 0);
    tick();
    chk("hs_nopulse", 32'(pulse_q.size()), 0);

    // auto, FS at WAIT cycle 10
    u_if.I_mode = `USB_SPEED_AUTO; u_if.I_start = 1'b1;
    tick();
    u_if.I_start = 1'b0;
    chk("fs_restart1", 32'(u_if.O_det_restart), 1);
    chk("fs_busy",     32'(u_if.O_busy), 1);
    chk("fs_unlocked", 32'(u_if.O_locked), 0);
    chk("fs_speed0",   32'(u_if.O_speed), 32'(`USB_SPEED_AUTO));
    tick();
    chk("fs_restart0", 32'(u_if.O_det_restart), 0);
    repeat (14) tick();
    chk("fs_prelock",  32'(u_if.O_locked), 0);
    u_if.I_det_speed = `USB_SPEED_FS;
    tick();
    chk("fs_locked",   32'(u_if.O_locked), 1);
    chk("fs_speed",    32'(u_if.O_speed), 32'(`USB_SPEED_FS));
    chk("fs_retries",  32'(u_if.O_retries), 0);
    chk("fs_busy0",    32'(u_if.O_busy), 0);
    chk("fs_pulses",   32'(pulse_q.size()), 1);

    // stale LS through RESTART+BLANK, then HS at WAIT cycle 3
    u_if.I_det_speed = `USB_SPEED_LS; u_if.I_start = 1'b1;
    tick();
    u_if.I_start = 1'b0;
    repeat (5) tick();
    chk("stale_nolock", 32'(u_if.O_locked), 0);
    chk("stale_busy",   32'(u_if.O_busy), 1);
    u_if.I_det_speed = `USB_SPEED_AUTO;
    repeat (3) tick();
    u_if.I_det_speed = `USB_SPEED_HS;
    tick();
    chk("stale_locked", 32'(u_if.O_locked), 1);
    chk("stale_speed",  32'(u_if.O_speed), 32'(`USB_SPEED_HS));

    // no response -> FAIL after 3 attempts
    pulse_q.delete();
    u_if.I_det_speed = `USB_SPEED_AUTO; u_if.I_start = 1'b1;
    tick();
    u_if.I_start = 1'b0;
    repeat (314) tick();
    chk("nr_err_early", 32'(u_if.O_error), 0);
    chk("nr_busy",      32'(u_if.O_busy), 1);
    chk("nr_retries_w", 32'(u_if.O_retries), 2);
    tick();
    chk("nr_error",     32'(u_if.O_error), 1);
    chk("nr_busy0",     32'(u_if.O_busy), 0);
    chk("nr_speed",     32'(u_if.O_speed), 32'(`USB_SPEED_AUTO));
    chk("nr_retries",   32'(u_if.O_retries), 2);
    chk("nr_pulses",    32'(pulse_q.size()), 3);
    if (pulse_q.size() == 3) begin
      chk("nr_gap1", 32'(pulse_q[1] - pulse_q[0]), 105);
      chk("nr_gap2", 32'(pulse_q[2] - pulse_q[1]), 105);
    end

    // abort from FAIL keeps retries
    u_if.I_abort = 1'b1;
    tick();
    u_if.I_abort = 1'b0;
    chk("ab_error0",  32'(u_if.O_error), 0);
    chk("ab_retries", 32'(u_if.O_retries), 2);

    // abort + start together in WAIT
    u_if.I_start = 1'b1;
    tick();
    u_if.I_start = 1'b0;
    repeat (5) tick();
    chk("as_inwait", 32'(u_if.O_busy), 1);
    n_pulses = pulse_q.size();
    u_if.I_abort = 1'b1; u_if.I_start = 1'b1;
    tick();
    u_if.I_abort = 1'b0; u_if.I_start = 1'b0;
    chk("as_busy0",    32'(u_if.O_busy), 0);
    chk("as_restart0", 32'(u_if.O_det_restart), 0);
    chk("as_locked0",  32'(u_if.O_locked), 0);
    tick();
    chk("as_nopulse",  32'(pulse_q.size()), 32'(n_pulses));

    // async reset mid-BLANK of the second attempt
    u_if.I_start = 1'b1;
    tick();
    u_if.I_start = 1'b0;
    repeat (107) tick();
    chk("rb_retries1", 32'(u_if.O_retries), 1);
    chk("rb_busy1",    32'(u_if.O_busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rb_busy",    32'(u_if.O_busy), 0);
    chk("rb_retries", 32'(u_if.O_retries), 0);
    chk("rb_restart", 32'(u_if.O_det_restart), 0);
    chk("rb_speed",   32'(u_if.O_speed), 32'(`USB_SPEED_AUTO));
    chk("rb_locked",  32'(u_if.O_locked), 0);
    chk("rb_error",   32'(u_if.O_error), 0);
    #2 reset_n = 1'b1;
    tick();

    // autodetected LS then detector drops out for 2 cycles
    u_if.I_start = 1'b1;
    tick();
    u_if.I_start = 1'b0;
    repeat (5) tick();
    u_if.I_det_speed = `USB_SPEED_LS;
    tick();
    chk("rl_locked", 32'(u_if.O_locked), 1);
    chk("rl_speed",  32'(u_if.O_speed), 32'(`USB_SPEED_LS));
    u_if.I_det_speed = `USB_SPEED_AUTO;
    tick();
    chk("rl_hold1",  32'(u_if.O_locked), 1);
    tick();
`ifdef USB_SEQ_RELOCK_EN
    chk("rl_restart", 32'(u_if.O_det_restart), 1);
    chk("rl_unlock",  32'(u_if.O_locked), 0);
`else
    chk("rl_restart", 32'(u_if.O_det_restart), 0);
    chk("rl_stay",    32'(u_if.O_locked), 1);
    chk("rl_stay_sp", 32'(u_if.O_speed), 32'(`USB_SPEED_LS));
`endif

    // forced lock ignores a missing detector in either build
    u_if.I_abort = 1'b1;
    tick();
    u_if.I_abort = 1'b0;
    u_if.I_mode = `USB_SPEED_LS; u_if.I_start = 1'b1;
    tick();
    u_if.I_start = 1'b0;
    n_pulses = pulse_q.size();
    repeat (3) tick();
    chk("fl_locked",  32'(u_if.O_locked), 1);
    chk("fl_speed",   32'(u_if.O_speed), 32'(`USB_SPEED_LS));
    chk("fl_nopulse", 32'(pulse_q.size()), 32'(n_pulses));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/usb_speed_sequencer.md
# usb_speed_sequencer

Supervisory controller for USB speed selection in the front-end (`fe_clk`) domain. On a start request it either applies a register-forced speed directly, or sequences the speed autodetector:
- pulses its restart;
- blanks its stale result;
- waits with a timeout, retrying a bounded number of times;
- latches and holds the detected speed for the capture path.

It reports lock, busy, error and retry count back to the register block.

## Interface
Parameters:
- `pTIMER_WIDTH`, 22, width of the blank/timeout counter
- `pTIMEOUT`, 3000000, WAIT-state cycles per attempt (50 ms at 60 MHz)
- `pBLANK`, 16, cycles after restart during which `I_det_speed` is ignored
- `pMAX_RETRIES`, 3, retries after the first attempt before failing (≤ 15)

Ports:
- `fe_clk`  in  1  front-end clock, sole clock of the block
- `reset_n`  in  1  asynchronous active-low reset
- `I_start`  in  1  one-cycle pulse: begin (or re-begin) speed selection
- `I_abort`  in  1  one-cycle pulse: drop to IDLE
- `I_mode`  in  2  requested speed, `` `USB_SPEED_AUTO``/`LS`/`FS`/`HS`; sampled only with `I_start`
- `I_det_speed`  in  2  autodetector result; `` `USB_SPEED_AUTO`` = no result
- `O_det_restart`  out  1  one-cycle restart pulse to the autodetector
- `O_speed`  out  2  applied speed, held while locked
- `O_locked`  out  1  `O_speed` valid
- `O_busy`  out  1  high in RESTART/BLANK/WAIT
- `O_error`  out  1  high in FAIL
- `O_retries`  out  4  restarts issued beyond the first in the current run

## Operation
States:
- **IDLE**
  - `I_start` with `I_mode` ≠ AUTO: `O_speed` ← `I_mode`, go to LOCKED.
  - `I_start` with `I_mode` = AUTO: `O_retries` ← 0, go to RESTART.
- **RESTART** (1 cycle): `O_det_restart` = 1, timer ← 0, go to BLANK.
- **BLANK**: timer counts; at timer = `pBLANK`−1 timer ← 0, go to WAIT. `I_det_speed` is ignored throughout.
- **WAIT**:
  - `I_det_speed` ≠ AUTO: `O_speed` ← `I_det_speed`, go to LOCKED.
  - Else at timer = `pTIMEOUT`−1: if `O_retries` = `pMAX_RETRIES`, go to FAIL; otherwise `O_retries`+1 and go to RESTART.
  - A valid result in the same cycle as the timeout wins (lock).
- **LOCKED**: `O_locked` = 1. Later changes on `I_det_speed` or `I_mode` are ignored. `I_start` re-runs exactly as from IDLE.
- **FAIL**: `O_error` = 1, `O_speed` = AUTO. `I_start` re-runs as from IDLE.

Global rules:
- `I_abort` in any state goes to IDLE; it clears `O_speed` to AUTO, `O_locked`, `O_error` and `O_busy`, and keeps `O_retries`.
- `I_abort` and `I_start` in the same cycle: abort wins.
- `I_start` while busy restarts the sequence at RESTART with `O_retries` ← 0.
- Timer saturates, never wraps. Retry counter never exceeds `pMAX_RETRIES`.
- Unused state encodings go to IDLE.

## Timing
- All outputs are registered.
- Reset values: `O_speed` = `` `USB_SPEED_AUTO``; `O_det_restart`, `O_locked`, `O_busy`, `O_error` = 0; `O_retries` = 0; state IDLE.
- Reset asserted mid-run returns everything to the reset values immediately.
- `I_start` sampled at edge E:
  - Forced mode: `O_locked`/`O_speed` valid after E.
  - Auto mode: `O_det_restart` high for exactly the cycle after E.
- Per attempt: 1 + `pBLANK` + `pTIMEOUT` cycles.
- Detection at WAIT cycle k: `O_locked` and `O_speed` update on the following edge (1-cycle latency).
- FAIL is reached (1+`pMAX_RETRIES`)·(1+`pBLANK`+`pTIMEOUT`) cycles after RESTART is first entered.

## Configuration
- `USB_SEQ_RELOCK_EN` defined: in LOCKED reached via autodetect, `I_det_speed` = AUTO for 2 consecutive cycles triggers RESTART with `O_retries` ← 0. `O_locked` drops with the restart pulse.
- `USB_SEQ_RELOCK_EN` undefined: LOCKED exits only on `I_start`/`I_abort`. Forced-mode locks never relock in either build.

## Test plan
Bench parameters: `pTIMEOUT`=100, `pBLANK`=4, `pMAX_RETRIES`=2.
- Forced HS: `I_mode`=HS, `I_start` → no `O_det_restart` pulse; `O_speed`=HS, `O_locked`=1 one cycle later.
- Auto, detector reports FS at WAIT cycle 10 → single restart pulse; `O_speed`=FS, `O_locked`=1 on the next edge; `O_retries`=0.
- Stale result: `I_det_speed`=LS held through RESTART+BLANK, then AUTO, then HS at WAIT cycle 3 → locks HS, not LS.
- No response → 3 restart pulses 105 cycles apart; `O_error`=1 at cycle 315 after first RESTART; `O_retries`=2.
- `I_abort` and `I_start` simultaneously in WAIT → IDLE, `O_busy`=0, no restart pulse. Async reset mid-BLANK → all outputs at reset values.
- Relock (`USB_SEQ_RELOCK_EN`): locked LS, `I_det_speed`→AUTO for 2 cycles → restart pulse, `O_locked`=0. Without the macro: remains locked LS.
